// File: rtl/aes_text_loader.sv
// Word-serial adapter around aes_cipher_top: packs four 32-bit words into text_in, pulses ld,
// then streams the captured text_out back as four words. Optional RUN timeout: AES_LOADER_TIMEOUT_EN.
module aes_text_loader #(
    parameter int WORDS       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         ld,
    output logic [127:0] text_in,
    input  logic         done,
    input  logic [127:0] text_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         busy,
    output logic         err
);

    if (WORDS != 4 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("aes_text_loader: only WORDS=4 and TIMEOUT_CYC>=1 are supported");
    end

    typedef enum logic [1:0] {FILL, LOAD, RUN, DRAIN} state_t;

    localparam logic [1:0] LAST_WORD = 2'(WORDS - 1);

    state_t       state;
    logic [1:0]   wc;
    logic [1:0]   rc;
    logic [127:0] result;

`ifdef AES_LOADER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] run_cnt;
`else
    assign err = 1'b0;
`endif

    assign in_ready = (state == FILL);
    // Word 0 of the result sits in the top 32 bits.
    assign out_data = result[32*(3 - int'(rc)) +: 32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FILL;
            wc        <= '0;
            rc        <= '0;
            text_in   <= '0;
            result    <= '0;
            ld        <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef AES_LOADER_TIMEOUT_EN
            run_cnt   <= '0;
            err       <= 1'b0;
`endif
        end else begin
            ld <= 1'b0;
            case (state)
                FILL: begin
                    if (in_valid) begin
                        text_in[32*(3 - int'(wc)) +: 32] <= in_data;
                        wc   <= wc + 1'b1;
                        busy <= 1'b1;
                        if (wc == LAST_WORD) begin
                            ld    <= 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    state <= RUN;
`ifdef AES_LOADER_TIMEOUT_EN
                    run_cnt <= '0;
`endif
                end
                RUN: begin
                    // done takes priority over an expiry in the same cycle.
                    if (done) begin
                        result    <= text_out;
                        out_valid <= 1'b1;
                        rc        <= '0;
                        state     <= DRAIN;
                    end
`ifdef AES_LOADER_TIMEOUT_EN
                    else if (run_cnt == RUN_LAST) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        wc    <= '0;
                        state <= FILL;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (out_ready) begin
                        rc <= rc + 1'b1;
                        if (rc == LAST_WORD) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            wc        <= '0;
                            state     <= FILL;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_text_loader.sv
// Directed bench for aes_text_loader: load/ld pulse, drain with and without backpressure,
// spurious done, mid-block reset and (with AES_LOADER_TIMEOUT_EN) the RUN timeout.
module tb_aes_text_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         ld;
    logic [127:0] text_in;
    logic         done = 1'b0;
    logic [127:0] text_out = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic         busy;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] BLK_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RES_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BLK_B = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] RES_B = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] BLK_C = 128'hcafef00d11112222333344445555aaaa;
    localparam logic [127:0] RES_C = 128'h0badc0de99998888777766665555bbbb;

    always #5 clk = ~clk;

    aes_text_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .ld       (ld),
        .text_in  (text_in),
        .done     (done),
        .text_out (text_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .err      (err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ld"}, ld, 1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    // Four back-to-back words, then the LOAD cycle and the first RUN cycle.
    task automatic send_block(input logic [127:0] blk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = blk[127-32*k -: 32];
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("ld_pulse", ld, 1'b1);
        check("text_in", text_in, blk);
        check("in_ready_load", in_ready, 1'b0);
        check("busy_load", busy, 1'b1);
        @(negedge clk);
        check("ld_one_cycle", ld, 1'b0);
        check("text_in_run", text_in, blk);
    endtask

    task automatic finish_block(input logic [127:0] blk, input logic [127:0] res, input bit toggle);
        int j;
        logic [31:0] exp_word;
        @(negedge clk);
        done     = 1'b1;
        text_out = res;
        @(negedge clk);
        done     = 1'b0;
        text_out = '0;
        j = 0;
        for (int c = 0; c < 20 && j < 4; c++) begin
            if (c > 0) @(negedge clk);
            exp_word = res[127-32*j -: 32];
            check("out_valid", out_valid, 1'b1);
            check("out_data", out_data, exp_word);
            out_ready = toggle ? (c % 2 == 0) : 1'b1;
            if (out_valid && out_ready) j++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_words", j, 4);
        check("out_valid_end", out_valid, 1'b0);
        check("busy_end", busy, 1'b0);
        check("in_ready_end", in_ready, 1'b1);
        check("text_in_held", text_in, blk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_text_in", text_in, 128'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_err", err, 1'b0);
        check_idle("rst");
        rst = 1'b1;

        // Basic load, in_valid ignored during RUN, full-rate drain
        send_block(BLK_A);
        in_valid = 1'b1;
        in_data  = 32'hdeadbeef;
        for (int c = 0; c < 3; c++) begin
            check("in_ready_run", in_ready, 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("text_in_no_take", text_in, BLK_A);
        finish_block(BLK_A, RES_A, 1'b0);

        // Toggled out_ready during DRAIN
        send_block(BLK_B);
        finish_block(BLK_B, RES_B, 1'b1);

        // done while in FILL is ignored
        @(negedge clk);
        done     = 1'b1;
        text_out = RES_C;
        @(negedge clk);
        done     = 1'b0;
        text_out = '0;
        check_idle("spurious");
        @(negedge clk);
        check("spurious_out_valid2", out_valid, 1'b0);

`ifdef AES_LOADER_TIMEOUT_EN
        send_block(BLK_C);
        repeat (63) @(negedge clk);
        check("to_err_before", err, 1'b0);
        check("to_in_ready_before", in_ready, 1'b0);
        @(negedge clk);
        check("to_err", err, 1'b1);
        check_idle("to");
        repeat (3) @(negedge clk);
        check("to_no_output", out_valid, 1'b0);
        send_block(BLK_A);
        finish_block(BLK_A, RES_A, 1'b0);
        check("to_err_sticky", err, 1'b1);
`endif

        // Reset after two words discards the partial block
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'hbad00000 + k;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_text_in", text_in, 128'h0);
        check("mid_rst_out_data", out_data, 32'h0);
        check("mid_rst_err", err, 1'b0);
        check_idle("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        send_block(BLK_C);
        finish_block(BLK_C, RES_C, 1'b0);
        check("final_err", err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
